// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receive/transmit
//                engines: receiver FSM state encoding, parity mode codes and
//                the baud tick divider calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        HOLD   = 3'd5
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per oversample tick, truncated. Callers must keep the result >= 2.
    function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running oversample tick generator. Emits a one-clock
//                pulse every DIV clocks while enabled. Disabling or
//                restarting zeroes the phase so the next tick lands exactly
//                DIV clocks later.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-low reset
//                en      - run enable; counter held at 0 when low
//                restart - synchronous phase restart
//                tick    - one-clock tick pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int c_cnt_w = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign tick = en && !restart && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/uart_receiver_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver_cfg
//  Description : Parametrised UART receive engine. 2-flop input synchroniser,
//                oversampled 3-point majority vote per bit, start-bit glitch
//                rejection, optional even/odd parity, 1 or 2 stop bits,
//                parity/framing/overrun flags and a valid/ready output.
//  Ports       : clk         - system clock
//                rst         - asynchronous active-low reset
//                rx_in       - serial line, idle high, asynchronous
//                data_out    - received payload (first wire bit = LSB)
//                data_valid  - data_out and error flags valid
//                data_ready  - consumer accepts the held word
//                parity_err  - parity mismatch on the held word
//                frame_err   - a stop bit voted low on the held word
//                overrun_err - sticky: a frame completed while a word was held
//                busy        - receiver not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver_cfg #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int c_div  = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int c_os_w = $clog2(OVERSAMPLE);
    localparam int c_bi_w = 4;

    localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_os_w-1:0] c_os_one  = c_os_w'(1);
    localparam logic [c_os_w-1:0] c_vote_a  = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0] c_vote_b  = c_os_w'(OVERSAMPLE / 2);
    localparam logic [c_os_w-1:0] c_vote_c  = c_os_w'(OVERSAMPLE / 2 + 1);

    localparam logic [c_bi_w-1:0] c_bi_one    = c_bi_w'(1);
    localparam logic [c_bi_w-1:0] c_data_last = c_bi_w'(DATA_BITS - 1);
    localparam logic [c_bi_w-1:0] c_stop_last = c_bi_w'(STOP_BITS - 1);
    localparam logic              c_par_odd   = (PARITY_MODE == PAR_ODD);

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_rx_s;
    logic       r_rx_prev;
    logic       r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx_in};
            r_rx_prev <= w_rx_s;
        end
    end

    assign w_rx_s = r_sync[1];

    // ------------------------------------------------------------------
    // State and tick timing
    // ------------------------------------------------------------------
    rx_state_t r_state;
    rx_state_t w_next;

    logic              w_tick;
    logic              w_baud_en;
    logic              w_commit;
    logic              w_start;
    logic [c_os_w-1:0] r_os_cnt;
    logic [c_os_w-1:0] w_os_idx;
    logic              w_vote_pt;
    logic              w_bit_end;
    logic [1:0]        r_samp;
    logic              w_vote;
    logic [c_bi_w-1:0] r_bit_idx;

    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_frame_acc;

    // A start is a falling edge, or a line already low on the first IDLE
    // clock after a cleanly stopped frame (back-to-back frames whose start
    // edge arrived after the early stop-bit commit).
    assign w_start = (r_state == IDLE) && !w_rx_s && (r_rx_prev || r_armed);

    uart_baud_tick #(
        .DIV(c_div)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (w_baud_en),
        .restart(w_start),
        .tick   (w_tick)
    );

    // The frame's start edge is tick position 0; the n-th tick after it is
    // position n mod OVERSAMPLE, so the vote ticks straddle the bit centre.
    assign w_os_idx  = (r_os_cnt == c_os_last) ? '0 : (r_os_cnt + c_os_one);
    assign w_vote_pt = w_tick && (w_os_idx == c_vote_c);
    assign w_bit_end = w_tick && (r_os_cnt == c_os_last);
    assign w_vote    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = START;
            end
            START: begin
                if (w_vote_pt && w_vote) w_next = IDLE;
                else if (w_bit_end)      w_next = DATA;
            end
            DATA: begin
                if (w_bit_end && (r_bit_idx == c_data_last))
                    w_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (w_bit_end) w_next = STOP;
            end
            STOP: begin
                // Commit at the last stop bit's vote point, not its end.
                if (w_vote_pt && (r_bit_idx == c_stop_last)) w_next = HOLD;
            end
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (r_state != IDLE);
        w_baud_en = (r_state != IDLE);
        w_commit  = (r_state == HOLD);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_os_cnt    <= '0;
            r_samp      <= 2'b11;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_frame_acc <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            if (r_state == IDLE)  r_os_cnt <= '0;
            else if (w_tick)      r_os_cnt <= w_os_idx;

            if (w_tick && (w_os_idx == c_vote_a)) r_samp[0] <= w_rx_s;
            if (w_tick && (w_os_idx == c_vote_b)) r_samp[1] <= w_rx_s;

            if (r_state != w_next) r_bit_idx <= '0;
            else if (w_bit_end)    r_bit_idx <= r_bit_idx + c_bi_one;

            if ((r_state == DATA) && w_vote_pt)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};

            if (w_start)
                r_par_acc <= 1'b0;
            else if ((r_state == PARITY) && w_vote_pt)
                r_par_acc <= w_vote ^ (^r_shift) ^ c_par_odd;

            if (w_start)
                r_frame_acc <= 1'b0;
            else if ((r_state == STOP) && w_vote_pt && !w_vote)
                r_frame_acc <= 1'b1;

            r_armed <= w_commit && !r_frame_acc;
        end
    end

    // ------------------------------------------------------------------
    // Output word, flags and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (w_commit) begin
            if (data_valid && !data_ready) begin
                // Held word wins; the new word is dropped.
                overrun_err <= 1'b1;
            end else begin
                // Either nothing held or the held word retires this clock.
                data_out   <= r_shift;
                parity_err <= r_par_acc;
                frame_err  <= r_frame_acc;
                data_valid <= 1'b1;
                if (data_valid) overrun_err <= 1'b0;
            end
        end else if (data_valid && data_ready) begin
            data_valid  <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver_cfg
//  Description : Self-checking bench for uart_receiver_cfg. Three instances
//                (8N1, 8E1, 7O2) at 160 clk/bit, each with its own line.
//                Table vectors plus randomized frames against a frame-level
//                reference model, and hand sequences for glitch, overrun and
//                mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver_cfg;

    localparam int c_clk_freq = 1_600_000;
    localparam int c_baud     = 10_000;
    localparam int c_bit_clk  = 160;

    typedef struct {
        int         inst;
        logic [8:0] data;
        int         par;       // -1 = correct parity bit, else forced 0/1
        logic [1:0] stops;     // stop bit values, first stop in bit 0
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] rx;
    logic [2:0] ready;
    logic [2:0] valid, perr, ferr, ovr, busy;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic [8:0] dout_a [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_stop_cyc = 0;

    int         cap_n    [3] = '{0, 0, 0};
    logic [8:0] cap_data [3];
    logic       cap_perr [3];
    logic       cap_ferr [3];
    int         cap_cyc  [3];

    vec_t vecs [8];

    uart_receiver_cfg #(.CLK_FREQ(c_clk_freq), .BAUD(c_baud), .OVERSAMPLE(16),
                        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .rx_in(rx[0]), .data_out(dout0), .data_valid(valid[0]),
        .data_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
        .overrun_err(ovr[0]), .busy(busy[0]));

    uart_receiver_cfg #(.CLK_FREQ(c_clk_freq), .BAUD(c_baud), .OVERSAMPLE(16),
                        .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx_in(rx[1]), .data_out(dout1), .data_valid(valid[1]),
        .data_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
        .overrun_err(ovr[1]), .busy(busy[1]));

    uart_receiver_cfg #(.CLK_FREQ(c_clk_freq), .BAUD(c_baud), .OVERSAMPLE(16),
                        .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .rx_in(rx[2]), .data_out(dout2), .data_valid(valid[2]),
        .data_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
        .overrun_err(ovr[2]), .busy(busy[2]));

    assign dout_a[0] = {1'b0, dout0};
    assign dout_a[1] = {1'b0, dout1};
    assign dout_a[2] = {2'b00, dout2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted word (valid & ready seen before the transfer edge).
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid[i] && ready[i]) begin
                cap_n[i]    = cap_n[i] + 1;
                cap_data[i] = dout_a[i];
                cap_perr[i] = perr[i];
                cap_ferr[i] = ferr[i];
                cap_cyc[i]  = cyc;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: frame format per instance
    // ------------------------------------------------------------------
    function automatic int n_data(input int inst);
        return (inst == 2) ? 7 : 8;
    endfunction

    function automatic int n_stop(input int inst);
        return (inst == 2) ? 2 : 1;
    endfunction

    // Parity bit a correct transmitter sends: even for inst 1, odd for inst 2.
    function automatic logic good_parity(input int inst, input logic [8:0] data);
        int ones = 0;
        for (int i = 0; i < n_data(inst); i++) ones += int'(data[i]);
        if (inst == 1) return logic'(ones % 2);
        return logic'((ones % 2) == 0);
    endfunction

    function automatic logic [15:0] build_bits(input int inst, input logic [8:0] data,
                                               input int par, input logic [1:0] stops,
                                               output int nb);
        logic [15:0] bits;
        int pos;
        bits = '1;
        pos  = 0;
        bits[pos] = 1'b0;
        pos++;
        for (int i = 0; i < n_data(inst); i++) begin
            bits[pos] = data[i];
            pos++;
        end
        if (inst != 0) begin
            bits[pos] = (par < 0) ? good_parity(inst, data) : logic'(par[0]);
            pos++;
        end
        for (int s = 0; s < n_stop(inst); s++) begin
            bits[pos] = stops[s];
            pos++;
        end
        nb = pos;
        return bits;
    endfunction

    function automatic vec_t model_vec(input int inst, input logic [8:0] data,
                                       input int par, input logic [1:0] stops);
        vec_t v;
        v.inst     = inst;
        v.data     = data;
        v.par      = par;
        v.stops    = stops;
        v.exp_data = data;
        v.exp_perr = (inst != 0) && (par >= 0) && (logic'(par[0]) != good_parity(inst, data));
        v.exp_ferr = 1'b0;
        for (int s = 0; s < n_stop(inst); s++) if (stops[s] == 1'b0) v.exp_ferr = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; abort_clk >= 0 stops driving after that many clocks.
    task automatic send_frame(input int inst, input logic [8:0] data, input int par,
                              input logic [1:0] stops, input int abort_clk);
        logic [15:0] bits;
        int nb;
        int nclk;
        bits = build_bits(inst, data, par, stops, nb);
        nclk = 0;
        for (int b = 0; b < nb; b++) begin
            if (b == nb - 1) last_stop_cyc = cyc;
            rx[inst] = bits[b];
            for (int k = 0; k < c_bit_clk; k++) begin
                if (abort_clk >= 0 && nclk == abort_clk) return;
                @(posedge clk);
                #1;
                nclk++;
            end
        end
        rx[inst] = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n0;
        int lat;
        n0 = cap_n[v.inst];
        send_frame(v.inst, v.data, v.par, v.stops, -1);
        step(2 * c_bit_clk);
        lat = cap_cyc[v.inst] - last_stop_cyc;
        check({tag, "_count"}, 32'(cap_n[v.inst] - n0), 32'd1);
        check({tag, "_data"},  32'(cap_data[v.inst]), 32'(v.exp_data));
        check({tag, "_perr"},  32'(cap_perr[v.inst]), 32'(v.exp_perr));
        check({tag, "_ferr"},  32'(cap_ferr[v.inst]), 32'(v.exp_ferr));
        check({tag, "_latency_window"}, 32'(lat >= 80 && lat <= 110), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy[v.inst]), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int   n0;
        int   inst;
        logic [8:0] d;
        int   par;
        logic [1:0] st;

        vecs[0] = '{0, 9'h0A5, -1, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h007,  0, 2'b11, 9'h007, 1'b1, 1'b0};
        vecs[2] = '{1, 9'h007,  1, 2'b11, 9'h007, 1'b0, 1'b0};
        vecs[3] = '{2, 9'h055, -1, 2'b01, 9'h055, 1'b0, 1'b1};
        vecs[4] = '{2, 9'h02A,  1, 2'b11, 9'h02A, 1'b1, 1'b0};
        vecs[5] = '{0, 9'h000, -1, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[6] = '{0, 9'h0FF, -1, 2'b10, 9'h0FF, 1'b0, 1'b1};
        vecs[7] = '{1, 9'h0C3, -1, 2'b11, 9'h0C3, 1'b0, 1'b0};

        rst   = 1'b0;
        rx    = 3'b111;
        ready = 3'b111;
        step(5);
        @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_errs",  32'({perr, ferr, ovr}), 32'd0);
        check("reset_dout",  32'({dout0, dout1, dout2}), 32'd0);
        step(1);
        rst = 1'b1;
        step(20);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Start-bit glitch: 40 clk low must be rejected.
        n0 = cap_n[0];
        rx[0] = 1'b0;
        step(20);
        check("glitch_busy_start", 32'(busy[0]), 32'd1);
        step(20);
        rx[0] = 1'b1;
        step(200);
        check("glitch_busy_idle", 32'(busy[0]), 32'd0);
        check("glitch_no_word", 32'(cap_n[0] - n0), 32'd0);
        check("glitch_valid", 32'(valid[0]), 32'd0);

        // Overrun: two words with the consumer stalled.
        ready[0] = 1'b0;
        send_frame(0, 9'h011, -1, 2'b11, -1);
        step(2 * c_bit_clk);
        check("ovr_first_valid", 32'(valid[0]), 32'd1);
        check("ovr_first_data",  32'(dout0), 32'h11);
        check("ovr_first_flag",  32'(ovr[0]), 32'd0);
        send_frame(0, 9'h022, -1, 2'b11, -1);
        step(2 * c_bit_clk);
        check("ovr_held_valid", 32'(valid[0]), 32'd1);
        check("ovr_held_data",  32'(dout0), 32'h11);
        check("ovr_flag_set",   32'(ovr[0]), 32'd1);
        n0 = cap_n[0];
        ready[0] = 1'b1;
        step(1);
        ready[0] = 1'b0;
        @(negedge clk);
        check("ovr_valid_drop", 32'(valid[0]), 32'd0);
        check("ovr_flag_clear", 32'(ovr[0]), 32'd0);
        check("ovr_xfer_count", 32'(cap_n[0] - n0), 32'd1);
        check("ovr_xfer_data",  32'(cap_data[0]), 32'h11);

        // Mid-frame reset while a word is also held.
        send_frame(0, 9'h05A, -1, 2'b11, -1);
        step(2 * c_bit_clk);
        check("rst_pre_valid", 32'(valid[0]), 32'd1);
        n0 = cap_n[0];
        send_frame(0, 9'h03C, -1, 2'b11, 720);
        rst   = 1'b0;
        rx[0] = 1'b1;
        step(3);
        @(negedge clk);
        check("rst_mid_dout",  32'(dout0), 32'd0);
        check("rst_mid_valid", 32'(valid[0]), 32'd0);
        check("rst_mid_errs",  32'({perr[0], ferr[0], ovr[0]}), 32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        step(1);
        rst      = 1'b1;
        ready[0] = 1'b1;
        step(2 * c_bit_clk);
        check("rst_no_partial", 32'(cap_n[0] - n0), 32'd0);
        run_vec("rst_after", model_vec(0, 9'h03C, -1, 2'b11));

        // Randomized frames against the model.
        for (int r = 0; r < 12; r++) begin
            inst = r % 3;
            d    = 9'($urandom) & ((inst == 2) ? 9'h07F : 9'h0FF);
            par  = (inst == 0) ? -1 : int'($urandom_range(0, 2)) - 1;
            if (inst == 2) st = 2'($urandom_range(0, 3));
            else           st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            step(int'($urandom_range(1, 50)));
            run_vec($sformatf("rnd%0d", r), model_vec(inst, d, par, st));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver_cfg.md
Name: uart_receiver_cfg

Overview:
- Parametrised UART receive engine; successor to the fixed 8N1 receiver in the telemetry board RX path.
- Generalises data width, parity mode, stop-bit count and baud timing.
- Adds oversampled majority-vote sampling, a 2-flop input synchroniser and start-bit glitch rejection.
- Adds parity, framing and overrun error flags, plus a valid/ready output handshake toward the telemetry packet parser.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 9600, line rate in bit/s
- OVERSAMPLE, 16, sample ticks per bit; even, 8..32
- DATA_BITS, 8, payload bits per frame; 5..9
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rx_in  in  1  serial line, idle high, asynchronous to clk
- data_out  out  DATA_BITS  received payload, LSB first on the wire
- data_valid  out  1  data_out and the error flags are valid
- data_ready  in  1  consumer accepts the word
- parity_err  out  1  parity mismatch on the held word
- frame_err  out  1  stop bit sampled low on the held word
- overrun_err  out  1  sticky; a frame completed while the previous word was still held
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low): all outputs 0, FSM to IDLE, synchroniser flops set to 1, counters 0. Assertion mid-frame aborts the frame; no partial word is ever presented.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated, must be ≥ 2.
  - One-clock tick pulse every TICK_DIV clocks; free-running.
  - Held at 0 in IDLE so that every frame starts phase-aligned.
- Sampling:
  - rx_s is rx_in after 2 flops.
  - Each bit's value is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, HOLD.
  - IDLE: on an rx_s falling edge, go to START and restart the tick counter.
  - START: at the majority point, a voted 1 is a glitch; return to IDLE with no output. A voted 0 finishes the bit period, then goes to DATA.
  - DATA: shifts DATA_BITS voted bits LSB-first into the shift register; bit index runs 0..DATA_BITS-1. Goes to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: computes expected = XOR(data) for even, ~XOR(data) for odd. Records the mismatch.
  - STOP: samples STOP_BITS stop bits. frame_err is set if any voted stop bit is 0. After the last stop bit's vote point (not its end), commits and goes to HOLD. This allows back-to-back frames with up to a half-bit clock mismatch.
  - HOLD: one clock only; goes to IDLE. Detecting a start edge already low in HOLD→IDLE: IDLE treats rx_s==0 with prior stop seen as a start.
- Commit (one clock in HOLD):
  - If data_valid is currently 1 and data_ready is 0: set overrun_err; the new word is dropped and the held word is kept.
  - Otherwise: load data_out, parity_err and frame_err, and set data_valid=1.
  - Simultaneous commit and data_ready=1 on the held word: the old word retires and the new one loads in the same clock; no overrun.
- Handshake:
  - data_valid falls the clock after data_valid & data_ready.
  - data_out and the flags are stable while valid and not ready.
- overrun_err clears only on reset or a data_valid & data_ready transfer.
- Latency: data_valid rises 2 clk (synchroniser) + 1 clk (commit) after the vote point of the last stop bit.
- DATA_BITS=9 with PARITY_MODE≠0 is legal; the frame is 12 or 13 bits long.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t (IDLE, START, DATA, PARITY, STOP, HOLD)
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - function tick_div(clk_freq, baud, oversample)
- One sub-module: uart_baud_tick, the tick generator with enable and synchronous restart. It is reused by the future transmitter.

Test Plan (CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 → 10 clk/tick, 160 clk/bit):
- 8N1 frame 0xA5, data_ready held 1 → data_valid pulses one clock, data_out=0xA5, all errors 0, busy low after the stop vote.
- 8E1 frame 0x07 with the parity bit driven 0 (wrong) → data_out=0x07, parity_err=1. Same frame with parity 1 → parity_err=0.
- 7O2 frame 0x55 with the second stop bit driven 0 → frame_err=1, data_out=0x55.
- rx_in low for 40 clk then high (glitch) → FSM returns to IDLE, no data_valid.
- data_ready held 0, two 8N1 frames 0x11 then 0x22 → data_out stays 0x11, overrun_err=1. Pulse data_ready → data_valid drops, overrun_err clears.
- rst driven low at 4.5 bits into a frame, then released → all outputs 0. The next clean frame 0x3C is received correctly.
